// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding
// and the default geometry of the register bank being dumped.
package regdump_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 32;

    // Dump sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Bundle of control, bank read-port and output-stream signals of the dump
// reader. The master modport is the reader's view, the slave modport is the
// view of the surrounding logic (bank + consumer).
// Optional feature macro: REGDUMP_PARITY_EN adds out_parity.
interface regdump_if
    import regdump_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef REGDUMP_PARITY_EN
    logic              out_parity;

    modport master (
        input  start, abort, start_addr, end_addr, rd_data, out_ready,
        output rd_addr, out_valid, out_data, out_addr, out_last, busy, done,
               out_parity
    );
    modport slave (
        output start, abort, start_addr, end_addr, rd_data, out_ready,
        input  rd_addr, out_valid, out_data, out_addr, out_last, busy, done,
               out_parity
    );
`else
    modport master (
        input  start, abort, start_addr, end_addr, rd_data, out_ready,
        output rd_addr, out_valid, out_data, out_addr, out_last, busy, done
    );
    modport slave (
        output start, abort, start_addr, end_addr, rd_data, out_ready,
        input  rd_addr, out_valid, out_data, out_addr, out_last, busy, done
    );
`endif
endinterface

// File: rtl/regdump_addr_ctr.sv
// Loadable wrap-around address counter for the dump reader. Holds the current
// register index and the captured end index, and flags the last entry.
module regdump_addr_ctr
    import regdump_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [ADDR_W-1:0] load_end_i,
    input  logic              incr_i,
    output logic [ADDR_W-1:0] cur_addr_o,
    output logic              is_last_o
);
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(NUM_REGS - 1);

    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] end_reg_q,  end_reg_d;

    // Next-state: load wins over increment; increment wraps past the top entry.
    always_comb begin
        cur_addr_d = cur_addr_q;
        end_reg_d  = end_reg_q;
        if (load_i) begin
            cur_addr_d = load_addr_i;
            end_reg_d  = load_end_i;
        end else if (incr_i) begin
            cur_addr_d = (cur_addr_q == TOP_ADDR) ? '0 : cur_addr_q + ADDR_W'(1);
        end
    end

    // Counter and end-address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_addr_q <= '0;
            end_reg_q  <= '0;
        end else begin
            cur_addr_q <= cur_addr_d;
            end_reg_q  <= end_reg_d;
        end
    end

    assign cur_addr_o = cur_addr_q;
    assign is_last_o  = (cur_addr_q == end_reg_q);

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks start_addr..end_addr (wrapping) through the
// bank's combinational read port and streams each entry over valid/ready.
// Optional feature macro: REGDUMP_PARITY_EN adds a registered out_parity.
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    regdump_if.master bus
);
    state_e            state_q, state_d;
    logic              load;
    logic              incr;
    logic              capture;
    logic [ADDR_W-1:0] cur_addr;
    logic              is_last;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              out_last_q;

    regdump_addr_ctr #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_addr_ctr (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .load_addr_i (bus.start_addr),
        .load_end_i  (bus.end_addr),
        .incr_i      (incr),
        .cur_addr_o  (cur_addr),
        .is_last_o   (is_last)
    );

    // Sequencer next-state and control; abort overrides everything else.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        incr        = 1'b0;
        capture     = 1'b0;
        out_valid_d = out_valid_q;
        if (bus.abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        load    = 1'b1;
                        state_d = READ;
                    end
                end
                READ: begin
                    capture     = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_d = 1'b0;
                        if (out_last_q) begin
                            state_d = DONE;
                        end else begin
                            incr    = 1'b1;
                            state_d = READ;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word register: loaded in READ, held stable through HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (capture) begin
                out_data_q <= bus.rd_data;
                out_addr_q <= cur_addr;
                out_last_q <= is_last;
            end
        end
    end

`ifdef REGDUMP_PARITY_EN
    logic out_parity_q;

    // Parity of the captured word, registered alongside out_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_parity_q <= 1'b0;
        end else if (capture) begin
            out_parity_q <= ^bus.rd_data;
        end
    end

    assign bus.out_parity = out_parity_q;
`endif

    // cur_addr is itself a register, so the read address only moves on edges.
    assign bus.rd_addr   = cur_addr;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

endmodule
